// File: rtl/io_responder_if.sv
// Bus-side port bundle of io_responder: region select, port number, direction,
// write data and the registered read data returned to the initiator.
interface io_responder_if;
   logic       io_en;
   logic [2:0] io_sel;
   logic       io_wr;
   logic [7:0] io_din;
   logic [7:0] io_dout;

   modport master (
      output io_en, io_sel, io_wr, io_din,
      input  io_dout
   );

   modport slave (
      input  io_en, io_sel, io_wr, io_din,
      output io_dout
   );
endinterface

// File: rtl/io_responder.sv
// Memory-mapped IO responder: UART TX/RX byte FIFOs, status/W1C port, halt port.
// Optional 32-bit cycle counter with snapshot when IO_CYCLE_COUNTER_EN is defined.
module io_responder #(
   parameter int FIFO_AW = 4
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rdy_in,
   io_responder_if.slave bus,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic       halt,
   output logic [7:0] halt_code
);
   // valid/ready: a byte moves on a rising edge where both valid and ready are
   // high; valid never depends on ready, and a pop is only made while nonempty.

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

   logic [7:0]         r_tx_mem [DEPTH];
   logic [FIFO_AW-1:0] r_tx_rptr, r_tx_wptr;
   logic [FIFO_AW:0]   r_tx_cnt;
   logic [7:0]         r_rx_mem [DEPTH];
   logic [FIFO_AW-1:0] r_rx_rptr, r_rx_wptr;
   logic [FIFO_AW:0]   r_rx_cnt;
   logic               r_tx_ovf, r_rx_ovf;
   logic               r_halt;
   logic [7:0]         r_halt_code;
   logic [7:0]         r_io_dout;

   logic       w_acc, w_rd, w_wr;
   logic       w_wr0, w_rd0, w_wr1, w_wr4;
   logic       w_tx_full, w_tx_nempty, w_rx_full, w_rx_nempty;
   logic       w_tx_push, w_tx_pop, w_tx_ovf_set, w_tx_ovf_clr;
   logic       w_rx_push, w_rx_pop, w_rx_ovf_set, w_rx_ovf_clr;
   logic [7:0] w_status;
   logic [7:0] w_rd_data;

   assign w_acc = bus.io_en & rdy_in;
   assign w_rd  = w_acc & ~bus.io_wr;
   assign w_wr  = w_acc &  bus.io_wr;
   assign w_wr0 = w_wr & (bus.io_sel == 3'd0);
   assign w_rd0 = w_rd & (bus.io_sel == 3'd0);
   assign w_wr1 = w_wr & (bus.io_sel == 3'd1);
   assign w_wr4 = w_wr & (bus.io_sel == 3'd4);

   assign w_tx_full   = (r_tx_cnt == FULL_CNT);
   assign w_tx_nempty = (r_tx_cnt != '0);
   assign w_rx_full   = (r_rx_cnt == FULL_CNT);
   assign w_rx_nempty = (r_rx_cnt != '0);

   // Fullness is judged on the registered count, so a same-cycle drain does not
   // make room for a write that arrives while full.
   assign w_tx_push    = w_wr0 & ~w_tx_full;
   assign w_tx_ovf_set = w_wr0 &  w_tx_full;
   assign w_tx_pop     = w_tx_nempty & tx_ready;
   assign w_tx_ovf_clr = w_wr1 & bus.io_din[2];

   assign w_rx_push    = rx_valid & ~w_rx_full;
   assign w_rx_ovf_set = rx_valid &  w_rx_full;
   assign w_rx_pop     = w_rd0 & w_rx_nempty;
   assign w_rx_ovf_clr = w_wr1 & bus.io_din[3];

   assign tx_valid    = w_tx_nempty;
   assign tx_data     = r_tx_mem[r_tx_rptr];
   assign rx_ready    = ~w_rx_full;
   assign halt        = r_halt;
   assign halt_code   = r_halt_code;
   assign bus.io_dout = r_io_dout;

   assign w_status = {4'b0000, r_rx_ovf, r_tx_ovf, w_tx_full, w_rx_nempty};

   always_ff @(posedge clk_in) begin
      if (w_tx_push && !rst_in) r_tx_mem[r_tx_wptr] <= bus.io_din;
      if (w_rx_push && !rst_in) r_rx_mem[r_rx_wptr] <= rx_data;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_tx_rptr <= '0;
         r_tx_wptr <= '0;
         r_tx_cnt  <= '0;
      end else begin
         if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
         if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
            2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
            default: r_tx_cnt <= r_tx_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_rx_rptr <= '0;
         r_rx_wptr <= '0;
         r_rx_cnt  <= '0;
      end else begin
         if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
         if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
            2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
            default: r_rx_cnt <= r_rx_cnt;
         endcase
      end
   end

   // Sticky overflow flags: a set in the same cycle as a clear wins.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_tx_ovf <= 1'b0;
         r_rx_ovf <= 1'b0;
      end else begin
         r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~w_tx_ovf_clr);
         r_rx_ovf <= w_rx_ovf_set | (r_rx_ovf & ~w_rx_ovf_clr);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_halt      <= 1'b0;
         r_halt_code <= 8'h00;
      end else if (w_wr4 && !r_halt) begin
         r_halt      <= 1'b1;
         r_halt_code <= bus.io_din;
      end
   end

`ifdef IO_CYCLE_COUNTER_EN
   logic [31:0] r_cyc_cnt;
   logic [31:0] r_snap;
   logic        w_rd4;

   assign w_rd4 = w_rd & (bus.io_sel == 3'd4);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_cyc_cnt <= '0;
         r_snap    <= '0;
      end else begin
         if (rdy_in && !r_halt) r_cyc_cnt <= r_cyc_cnt + 32'd1;
         if (w_rd4)             r_snap    <= r_cyc_cnt;
      end
   end
`endif

   always_comb begin
      w_rd_data = 8'h00;
      case (bus.io_sel)
         3'd0:    w_rd_data = w_rx_nempty ? r_rx_mem[r_rx_rptr] : 8'h00;
         3'd1:    w_rd_data = w_status;
`ifdef IO_CYCLE_COUNTER_EN
         // Port 4 returns the value being latched, so byte 0 matches the new snapshot.
         3'd4:    w_rd_data = r_cyc_cnt[7:0];
         3'd5:    w_rd_data = r_snap[15:8];
         3'd6:    w_rd_data = r_snap[23:16];
         3'd7:    w_rd_data = r_snap[31:24];
`endif
         default: w_rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in)    r_io_dout <= 8'h00;
      else if (w_rd) r_io_dout <= w_rd_data;
   end

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: drivers push expected bytes into queues and a
// negedge monitor pops and compares whenever a TX byte or read response appears.
module tb_io_responder;
   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       rdy_in;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       halt;
   logic [7:0] halt_code;

   always #5 clk_in = ~clk_in;

   io_responder_if bus ();

   io_responder #(.FIFO_AW(4)) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .bus       (bus),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .halt      (halt),
      .halt_code (halt_code)
   );

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_tx_q[$];
   logic [7:0] exp_rd_q[$];
   logic       rd_pending = 1'b0;

`ifdef IO_CYCLE_COUNTER_EN
   localparam logic [7:0] EXP_P4 = 8'h2C;
   localparam logic [7:0] EXP_P5 = 8'h01;
`else
   localparam logic [7:0] EXP_P4 = 8'h00;
   localparam logic [7:0] EXP_P5 = 8'h00;
`endif

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic extra(input string name, input logic [7:0] act);
      n_vec++;
      n_err++;
      $display("FAIL %s: got %02h expected nothing at %0t", name, act, $time);
   endtask

   // Monitor: sampled mid-cycle; inputs change 1 time unit after each rising edge.
   always @(negedge clk_in) begin
      if (rst_in) begin
         rd_pending = 1'b0;
      end else begin
         if (rd_pending) begin
            if (exp_rd_q.size() == 0) extra("rd_extra", bus.io_dout);
            else check("rd_data", bus.io_dout, exp_rd_q.pop_front());
         end
         rd_pending = bus.io_en & rdy_in & ~bus.io_wr;
         if (tx_valid && tx_ready) begin
            if (exp_tx_q.size() == 0) extra("tx_extra", tx_data);
            else check("tx_data", tx_data, exp_tx_q.pop_front());
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] sel, input logic [7:0] d);
      bus.io_en  = 1'b1;
      bus.io_wr  = 1'b1;
      bus.io_sel = sel;
      bus.io_din = d;
      @(posedge clk_in);
      #1;
      bus.io_en  = 1'b0;
      bus.io_wr  = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] sel, input logic [7:0] exp);
      exp_rd_q.push_back(exp);
      bus.io_en  = 1'b1;
      bus.io_wr  = 1'b0;
      bus.io_sel = sel;
      @(posedge clk_in);
      #1;
      bus.io_en  = 1'b0;
   endtask

   task automatic rx_push(input logic [7:0] d);
      rx_valid = 1'b1;
      rx_data  = d;
      @(posedge clk_in);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic tx_write(input logic [7:0] d, input bit accepted);
      if (accepted) exp_tx_q.push_back(d);
      bus_write(3'd0, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_in     = 1'b1;
      rdy_in     = 1'b1;
      tx_ready   = 1'b0;
      rx_valid   = 1'b0;
      rx_data    = 8'h00;
      bus.io_en  = 1'b0;
      bus.io_wr  = 1'b0;
      bus.io_sel = 3'd0;
      bus.io_din = 8'h00;
      idle(3);
      rst_in = 1'b0;

      check("rst_dout",      bus.io_dout,       8'h00);
      check("rst_halt",      {7'b0, halt},      8'h00);
      check("rst_halt_code", halt_code,         8'h00);
      check("rst_tx_valid",  {7'b0, tx_valid},  8'h00);
      check("rst_rx_ready",  {7'b0, rx_ready},  8'h01);

      // Two bytes stream out in order.
      tx_ready = 1'b1;
      tx_write(8'h41, 1'b1);
      tx_write(8'h42, 1'b1);
      idle(4);
      check("tx_drain_basic", 8'(exp_tx_q.size()), 8'h00);
      check("tx_idle_valid",  {7'b0, tx_valid},    8'h00);

      // Fill TX while stalled; the 17th byte is dropped and flags overflow.
      tx_ready = 1'b0;
      for (int i = 0; i < 17; i++) tx_write(8'(8'h10 + i), i < 16);
      bus_read(3'd1, 8'h06);
      bus_write(3'd1, 8'h04);
      bus_read(3'd1, 8'h02);
      tx_ready = 1'b1;
      idle(20);
      check("tx_drain_full", 8'(exp_tx_q.size()), 8'h00);
      bus_read(3'd1, 8'h00);

      // Fill RX past capacity, clear rx_ovf, then drain in order.
      for (int i = 0; i < 17; i++) rx_push(8'(8'hA0 + i));
      check("rx_ready_full", {7'b0, rx_ready}, 8'h00);
      bus_read(3'd1, 8'h09);
      bus_write(3'd1, 8'h08);
      bus_read(3'd1, 8'h01);
      for (int i = 0; i < 16; i++) bus_read(3'd0, 8'(8'hA0 + i));
      bus_read(3'd1, 8'h00);

      // Single RX byte, then a read of an empty RX.
      rx_push(8'h5A);
      bus_read(3'd0, 8'h5A);
      bus_read(3'd0, 8'h00);
      bus_read(3'd1, 8'h00);

      // A read with rdy_in low is not accepted.
      rx_push(8'h77);
      bus_read(3'd1, 8'h01);
      idle(2);
      rdy_in     = 1'b0;
      bus.io_en  = 1'b1;
      bus.io_wr  = 1'b0;
      bus.io_sel = 3'd0;
      idle(1);
      bus.io_en  = 1'b0;
      rdy_in     = 1'b1;
      check("dout_hold", bus.io_dout, 8'h01);
      bus_read(3'd1, 8'h01);
      bus_read(3'd0, 8'h77);
      bus_read(3'd2, 8'h00);
      bus_read(3'd3, 8'h00);

      // Halt captures the first code only; TX still drains afterwards.
      bus_write(3'd4, 8'h07);
      check("halt_set",  {7'b0, halt}, 8'h01);
      check("halt_code", halt_code,    8'h07);
      bus_write(3'd4, 8'h09);
      check("halt_code_sticky", halt_code, 8'h07);
      tx_write(8'h99, 1'b1);
      bus_write(3'd2, 8'hFF);
      bus_write(3'd5, 8'hFF);
      idle(3);
      check("tx_drain_halt", 8'(exp_tx_q.size()), 8'h00);
      bus_read(3'd1, 8'h00);
      idle(2);

      // Cycle counter: 300 counting edges after reset, then ports 4, 5, 6.
      rst_in = 1'b1;
      idle(2);
      rst_in = 1'b0;
      check("rst2_halt", {7'b0, halt}, 8'h00);
      repeat (300) @(posedge clk_in);
      #1;
      bus_read(3'd4, EXP_P4);
      bus_read(3'd5, EXP_P5);
      bus_read(3'd6, 8'h00);
      idle(3);

      check("rd_queue_empty", 8'(exp_rd_q.size()), 8'h00);
      check("tx_queue_empty", 8'(exp_tx_q.size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
